// File: rtl/mini16_uart_rx.sv
// mini16_uart_rx: UART receiver for the mini16 SoC serial port.
// 8N1 frames on uart_rxd are oversampled 16x, each bit is decided by a
// 2-of-3 majority of the samples at sub=7,8,9, and completed bytes are
// offered on a valid/ready stream. Start glitches are rejected; framing
// and overrun conditions are reported as one-cycle pulses.
// Optional build macro UART_RX_PARITY_EN: 8E1 frames with an err_parity pulse.
module mini16_uart_rx #(
    parameter int CLK_HZ  = 140000000,
    parameter int SCLK_HZ = 115200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rxd,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       err_frame,
    output logic       err_overrun,
`ifdef UART_RX_PARITY_EN
    output logic       err_parity,
`endif
    output logic       busy
);

    // Oversample divider; the integration must keep this >= 2.
    localparam int DIV   = CLK_HZ / (SCLK_HZ * 16);
    localparam int CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [1:0]       sync_q;
    logic             rxs;

    logic [CNT_W-1:0] div_cnt;
    logic             tick;
    logic [3:0]       sub;

    logic [1:0]       samp;
    logic             maj;
    logic             decide;
    logic             bit_end;

    logic [2:0]       bit_idx;
    logic [7:0]       shift;

    logic             start_det;
    logic             shift_en;
    logic             byte_done;
    logic             frame_bad;

`ifdef UART_RX_PARITY_EN
    logic             par_check;
    logic             par_bad;
    logic             par_bad_q;
`endif

    // Two-flop synchroniser; the line idles high, so reset to all ones.
    always_ff @(posedge clk) begin
        // NOTE: every flop uses <= so all registers update from pre-edge values.
        if (reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], uart_rxd};
        end
    end

    assign rxs = sync_q[1];

    // Oversample tick generator, realigned to the detected start edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (start_det || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign tick = (div_cnt == DIV_LAST);

    // Sub-bit position: 16 ticks per bit, wraps 15 -> 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            sub <= '0;
        end else if (start_det) begin
            sub <= '0;
        end else if (tick) begin
            sub <= sub + 4'd1;
        end
    end

    assign decide  = tick && (sub == 4'd9);
    assign bit_end = tick && (sub == 4'd15);

    // The third sample is the live rxs on the deciding tick.
    assign maj = (samp[0] & samp[1]) | (samp[0] & rxs) | (samp[1] & rxs);

`ifdef UART_RX_PARITY_EN
    // Even parity: the parity bit must equal the XOR of the data bits.
    assign par_bad = (maj != ^shift);
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and per-cycle control strobes.
    always_comb begin
        // NOTE: defaults first so every path assigns every signal; no latches.
        state_nxt = state;
        start_det = 1'b0;
        shift_en  = 1'b0;
        byte_done = 1'b0;
        frame_bad = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_check = 1'b0;
`endif
        unique case (state)
            S_IDLE: begin
                if (!rxs) begin
                    start_det = 1'b1;
                    state_nxt = S_START;
                end
            end
            S_START: begin
                // A start bit that votes high was a glitch: drop it silently.
                if (decide && maj) begin
                    state_nxt = S_IDLE;
                end else if (bit_end) begin
                    state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                shift_en = decide;
                if (bit_end && (bit_idx == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
                    state_nxt = S_PARITY;
`else
                    state_nxt = S_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                par_check = decide;
                if (bit_end) begin
                    state_nxt = S_STOP;
                end
            end
`endif
            S_STOP: begin
                // Leave at mid-stop-bit so the next start edge has margin.
                if (decide) begin
                    if (maj) begin
`ifdef UART_RX_PARITY_EN
                        byte_done = !par_bad_q;
`else
                        byte_done = 1'b1;
`endif
                        state_nxt = S_IDLE;
                    end else begin
                        frame_bad = 1'b1;
                        state_nxt = S_WAIT_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                // Covers a line break: wait for the line to return high.
                if (rxs) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Sample capture, bit index and LSB-first shift register.
    always_ff @(posedge clk) begin
        // NOTE: datapath registers have no reset; each is written before use in a frame.
        if (tick && (sub == 4'd7)) begin
            samp[0] <= rxs;
        end
        if (tick && (sub == 4'd8)) begin
            samp[1] <= rxs;
        end
        if ((state == S_START) && bit_end) begin
            bit_idx <= 3'd0;
        end else if ((state == S_DATA) && bit_end) begin
            bit_idx <= bit_idx + 3'd1;
        end
        if (shift_en) begin
            shift <= {maj, shift[7:1]};
        end
    end

`ifdef UART_RX_PARITY_EN
    // Parity verdict for the current frame and its error pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            par_bad_q  <= 1'b0;
            err_parity <= 1'b0;
        end else begin
            err_parity <= par_check && par_bad;
            if (par_check) begin
                par_bad_q <= par_bad;
            end
        end
    end
`endif

    // Output stream register, handshake and error pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_data    <= 8'h00;
            out_valid   <= 1'b0;
            err_frame   <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            err_frame   <= frame_bad;
            err_overrun <= byte_done && out_valid && !out_ready;
            // A handshake in the completion cycle frees the slot for the new byte.
            if (byte_done && (!out_valid || out_ready)) begin
                out_data  <= shift;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_mini16_uart_rx.sv
// Self-checking bench for mini16_uart_rx: directed frames plus random bytes,
// checked against a frame-level model of what the consumer should receive.
`timescale 1ns/1ps
module tb_mini16_uart_rx;

    localparam int CLK_HZ   = 1600000;
    localparam int SCLK_HZ  = 10000;
    localparam int OVS      = CLK_HZ / (SCLK_HZ * 16);   // 10 clk per oversample
    localparam int BIT_CLKS = CLK_HZ / SCLK_HZ;          // 160 clk per bit
    localparam int LAT_NOM  = 1536 + 2;
    localparam int LAT_TOL  = 10;
`ifdef UART_RX_PARITY_EN
    localparam int STOP_BIT = 10;
`else
    localparam int STOP_BIT = 9;
`endif
    // Completion cycle, counted from the clk that drives the start edge:
    // 2 synchroniser clk + 1 detect clk, then the stop-bit decision on
    // oversample tick (STOP_BIT*16 + 9), each tick OVS clk after the last.
    localparam int DONE_OFS = 3 + (STOP_BIT * 16 + 10) * OVS - 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       uart_rxd;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       err_frame;
    logic       err_overrun;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       err_parity;
`endif

    mini16_uart_rx #(
        .CLK_HZ  (CLK_HZ),
        .SCLK_HZ (SCLK_HZ)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .uart_rxd    (uart_rxd),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .err_frame   (err_frame),
        .err_overrun (err_overrun),
`ifdef UART_RX_PARITY_EN
        .err_parity  (err_parity),
`endif
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // Monitor: observes the stream and error pulses on the falling edge.
    logic [7:0] rx_q[$];
    int frame_pulses   = 0;
    int overrun_pulses = 0;
    int parity_pulses  = 0;
    int both_pulses    = 0;
    int valid_rises    = 0;
    int valid_hi       = 0;
    int last_rise_cyc  = 0;
    logic valid_d      = 1'b0;

    always @(negedge clk) begin
        if (out_valid && out_ready) rx_q.push_back(out_data);
        if (err_frame) frame_pulses++;
        if (err_overrun) overrun_pulses++;
        if (err_frame && err_overrun) both_pulses++;
`ifdef UART_RX_PARITY_EN
        if (err_parity) parity_pulses++;
`endif
        if (out_valid) valid_hi++;
        if (out_valid && !valid_d) begin
            valid_rises++;
            last_rise_cyc = cyc;
        end
        valid_d = out_valid;
    end

    // Frame-level reference model: bytes the consumer must eventually see.
    logic [7:0] exp_q[$];
    int exp_overrun = 0;
    int exp_frame   = 0;
    int exp_parity  = 0;
    bit m_pending   = 1'b0;

    task automatic model_frame(input logic [7:0] d, input bit stop_ok, input bit par_ok,
                               input bit ready_at_done, input bit ready_after);
        if (!par_ok) exp_parity++;
        if (!stop_ok) begin
            exp_frame++;
        end else if (par_ok) begin
            if (m_pending && !ready_at_done) begin
                exp_overrun++;
            end else begin
                exp_q.push_back(d);
                m_pending = !ready_after;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Compare delivered bytes with the model, leaving a still-pending byte queued.
    task automatic check_rx(input string tag);
        int pend;
        pend = m_pending ? 1 : 0;
        check({tag, "_count"}, rx_q.size(), exp_q.size() - pend);
        while (rx_q.size() > 0 && exp_q.size() > pend)
            check({tag, "_byte"}, rx_q.pop_front(), exp_q.pop_front());
        rx_q.delete();
        while (exp_q.size() > pend) void'(exp_q.pop_front());
    endtask

    task automatic wait_clk(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_body(input logic [7:0] d, input bit par_flip);
        uart_rxd = 1'b0;
        wait_clk(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = d[i];
            wait_clk(BIT_CLKS);
        end
        uart_rxd = (^d) ^ par_flip;
        wait_clk(BIT_CLKS);
    endtask

    task automatic send_byte(input logic [7:0] d);
        send_body(d, 1'b0);
        uart_rxd = 1'b1;
        wait_clk(BIT_CLKS);
    endtask
`else
    task automatic send_body(input logic [7:0] d);
        uart_rxd = 1'b0;
        wait_clk(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = d[i];
            wait_clk(BIT_CLKS);
        end
    endtask

    task automatic send_byte(input logic [7:0] d);
        send_body(d);
        uart_rxd = 1'b1;
        wait_clk(BIT_CLKS);
    endtask
`endif

    // Watchdog: the sequence below is a fixed number of clk long.
    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    int start_cyc;
    int lat;
    int rises0;
    int hi0;
    int ov0;
    logic [7:0] rnd;

    initial begin
        reset     = 1'b1;
        uart_rxd  = 1'b1;
        out_ready = 1'b0;
        wait_clk(5);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_err_frame", err_frame, 1'b0);
        check("rst_err_overrun", err_overrun, 1'b0);
        reset = 1'b0;
        wait_clk(20);
        check("idle_busy", busy, 1'b0);

        // 0xA5 with the consumer always ready.
        out_ready = 1'b1;
        rises0    = valid_rises;
        hi0       = valid_hi;
        start_cyc = cyc;
        send_byte(8'hA5);
        model_frame(8'hA5, 1'b1, 1'b1, 1'b1, 1'b1);
        wait_clk(10);
        check_rx("a5");
        check("a5_valid_rises", valid_rises - rises0, 1);
        check("a5_valid_width", valid_hi - hi0, 1);
        lat = last_rise_cyc - start_cyc;
        checks++;
        assert (lat >= LAT_NOM - LAT_TOL && lat <= LAT_NOM + LAT_TOL) else begin
            errors++;
            $error("FAIL a5_latency: observed=%0d expected=%0d+/-%0d", lat, LAT_NOM, LAT_TOL);
        end
        check("a5_err_frame", frame_pulses, exp_frame);
        check("a5_err_overrun", overrun_pulses, exp_overrun);

        // Random bytes separated by random idle gaps.
        for (int k = 0; k < 4; k++) begin
            rnd = 8'($urandom);
            wait_clk($urandom_range(1, 30));
            send_byte(rnd);
            model_frame(rnd, 1'b1, 1'b1, 1'b1, 1'b1);
        end
        wait_clk(10);
        check_rx("rand");

        // Back-to-back 0x3C, 0xC3 with nobody consuming: second one overruns.
        out_ready = 1'b0;
        send_byte(8'h3C);
        model_frame(8'h3C, 1'b1, 1'b1, 1'b0, 1'b0);
        send_byte(8'hC3);
        model_frame(8'hC3, 1'b1, 1'b1, 1'b0, 1'b0);
        wait_clk(10);
        check("ovr_valid_held", out_valid, 1'b1);
        check("ovr_data_held", out_data, 8'h3C);
        check("ovr_pulses", overrun_pulses, exp_overrun);
        check_rx("ovr_none_yet");
        out_ready = 1'b1;
        m_pending = 1'b0;
        wait_clk(5);
        check_rx("ovr_drain");
        check("ovr_valid_drop", out_valid, 1'b0);

        // 0x11 pending, out_ready raised in the completion cycle of 0x22.
        out_ready = 1'b0;
        send_byte(8'h11);
        model_frame(8'h11, 1'b1, 1'b1, 1'b0, 1'b0);
        ov0 = overrun_pulses;
        fork
            send_byte(8'h22);
            begin
                wait_clk(DONE_OFS);
                out_ready = 1'b1;
                wait_clk(1);
                @(negedge clk);
                check("hs_data_next", out_data, 8'h22);
                check("hs_valid_next", out_valid, 1'b1);
            end
        join
        model_frame(8'h22, 1'b1, 1'b1, 1'b1, 1'b1);
        wait_clk(5);
        check("hs_no_overrun", overrun_pulses - ov0, 0);
        check_rx("hs");

        // 0x55 with the stop bit held low for 3 bit times.
`ifdef UART_RX_PARITY_EN
        send_body(8'h55, 1'b0);
`else
        send_body(8'h55);
`endif
        uart_rxd = 1'b0;
        wait_clk(3 * BIT_CLKS);
        model_frame(8'h55, 1'b0, 1'b1, 1'b1, 1'b1);
        check("fe_pulses", frame_pulses, exp_frame);
        check("fe_busy_low_line", busy, 1'b1);
        check("fe_no_valid", out_valid, 1'b0);
        check_rx("fe");
        uart_rxd = 1'b1;
        wait_clk(10);
        check("fe_busy_released", busy, 1'b0);
        send_byte(8'h0F);
        model_frame(8'h0F, 1'b1, 1'b1, 1'b1, 1'b1);
        wait_clk(10);
        check_rx("fe_recover");

        // 40-clk low glitch on an idle line.
        rises0   = valid_rises;
        uart_rxd = 1'b0;
        wait_clk(40);
        uart_rxd = 1'b1;
        wait_clk(300);
        check("gl_busy", busy, 1'b0);
        check("gl_no_valid", valid_rises - rises0, 0);
        check("gl_err_frame", frame_pulses, exp_frame);
        check_rx("gl");

        // Reset in the middle of data bit 4 of 0xFF while a byte is pending.
        out_ready = 1'b0;
        rnd = 8'($urandom);
        send_byte(rnd);
        model_frame(rnd, 1'b1, 1'b1, 1'b0, 1'b0);
        check("mr_pending_valid", out_valid, 1'b1);
        fork
            send_byte(8'hFF);
            begin
                wait_clk(5 * BIT_CLKS + BIT_CLKS / 2);
                reset = 1'b1;
                wait_clk(1);
                check("mr_valid", out_valid, 1'b0);
                check("mr_data", out_data, 8'h00);
                check("mr_busy", busy, 1'b0);
                reset = 1'b0;
            end
        join
        void'(exp_q.pop_back());
        m_pending = 1'b0;
        wait_clk(10);
        check_rx("mr_dropped");
        out_ready = 1'b1;
        send_byte(8'h81);
        model_frame(8'h81, 1'b1, 1'b1, 1'b1, 1'b1);
        wait_clk(10);
        check_rx("mr_recover");

`ifdef UART_RX_PARITY_EN
        // Even parity: correct bit delivers, flipped bit is discarded.
        send_byte(8'h07);
        model_frame(8'h07, 1'b1, 1'b1, 1'b1, 1'b1);
        wait_clk(10);
        check_rx("par_ok");
        rises0 = valid_rises;
        send_body(8'h07, 1'b1);
        uart_rxd = 1'b1;
        wait_clk(BIT_CLKS);
        model_frame(8'h07, 1'b1, 1'b0, 1'b1, 1'b1);
        wait_clk(10);
        check("par_pulses", parity_pulses, exp_parity);
        check("par_no_valid", valid_rises - rises0, 0);
        check_rx("par_bad");
`endif

        check("final_overrun", overrun_pulses, exp_overrun);
        check("final_frame", frame_pulses, exp_frame);
        check("final_parity", parity_pulses, exp_parity);
        check("err_exclusive", both_pulses, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mini16_uart_rx.md
Name: mini16_uart_rx

Overview:
- UART receiver for the mini16 SoC serial port: 8N1 frames on the asynchronous uart_rxd pin become bytes on a valid/ready stream.
- Consumers are the SoC host-loader and the I/O register bank.
- Counterpart of the SoC UART transmitter.
- Uses 16x oversampling, majority-vote bit sampling, false-start rejection, framing and overrun error reporting.

Parameters:
- CLK_HZ, 140000000, system clock frequency in Hz.
- SCLK_HZ, 115200, serial baud rate.
- DIV, CLK_HZ/(SCLK_HZ*16), oversample divider (integer division, truncated); must be >= 2. Default evaluates to 75.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous reset, active-high.
- uart_rxd  in  1  asynchronous serial input; idle high.
- out_data  out  8  received byte, LSB first on the wire.
- out_valid  out  1  out_data holds an unconsumed byte.
- out_ready  in  1  consumer accepts; a transfer occurs when out_valid && out_ready.
- err_frame  out  1  one-cycle pulse: stop bit sampled low.
- err_overrun  out  1  one-cycle pulse: byte completed while the previous byte was unconsumed.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: out_data=0, out_valid=0, err_frame=0, err_overrun=0, busy=0, state=IDLE, synchroniser flops=1.
- Input path: uart_rxd passes through a 2-flop synchroniser giving rxs. All decisions use rxs.
- Tick generator: counter 0..DIV-1. tick=1 for one clk when counter==DIV-1. Counter cleared on entry to START so bit timing aligns to the detected edge.
- Sub-bit counter sub, 4 bits: increments on each tick, wraps 15->0.
- Within each bit, samples are taken at sub=7,8,9. The bit value is the 2-of-3 majority, decided on the sub=9 tick.
- State machine:
  - IDLE: rxs==0 -> START with sub=0.
  - START: on decision, value 1 -> IDLE (glitch, nothing reported). On the sub=15 tick -> DATA with bit index 0.
  - DATA: on decision, shift the value into shift[7] with a right shift. On the sub=15 tick, index 7 -> STOP, else index+1.
  - STOP: on decision, value 1 -> complete the byte and go to IDLE. Value 0 -> err_frame pulse, byte discarded, go to WAIT_IDLE.
  - WAIT_IDLE: remain until rxs==1, then IDLE. This covers line break.
- Returning to IDLE at mid-stop-bit (sub=9) gives resync margin for the next start edge.
- Completion, on the clk after the stop decision:
  - If out_valid==0, or out_ready==1 in the completion cycle: out_data<=shift and out_valid<=1. A simultaneous handshake consumes the old byte; no overrun.
  - Else out_data is unchanged, the new byte is dropped, and err_overrun pulses.
- Handshake: out_valid stays high and out_data stays stable until out_valid && out_ready. out_valid then drops next clk unless a new byte loads in the same cycle.
- Latency: out_valid rises 1 clk after the STOP sub=9 tick, about 9.6 bit periods after the start edge plus 2 synchroniser clks.
- Reset mid-frame: the frame is abandoned and all outputs take their reset values the next clk. A line still low after reset is seen as a start edge.
- err_frame and err_overrun never assert in the same cycle.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- When defined: frame is 8E1, with a PARITY state between DATA and STOP using the same sampling. If the majority value differs from the XOR of the data bits, err_parity pulses, the byte is discarded, and the FSM continues to STOP. A port err_parity (out, 1, reset 0) is added.
- When undefined: 8N1 only, no PARITY state, no err_parity port.

Test Plan:
- Bench uses CLK_HZ=1600000, SCLK_HZ=10000, giving DIV=10 and a bit of 160 clk.
- Send 0xA5 with out_ready=1 -> out_valid pulses 1 clk with out_data=0xA5; rise occurs about 1536+2 clk after the start edge (±10); no error pulses.
- Send 0x3C then 0xC3 back-to-back with out_ready=0 -> out_data=0x3C held, out_valid=1, err_overrun pulses once at the second completion. Raising out_ready then gives one transfer of 0x3C.
- Hold out_ready=0, send 0x11, then raise out_ready exactly in the completion cycle of a following 0x22 -> no err_overrun; out_data=0x22 the next clk.
- Send 0x55 with the stop bit driven low for 3 bit times -> err_frame pulses once, out_valid stays 0, busy stays 1 until the line goes high. A subsequent 0x0F is received correctly.
- Drive a 40-clk low glitch on idle -> FSM returns to IDLE, no output, no error. Assert reset mid-data-bit 4 of 0xFF -> outputs reset; the next frame 0x81 is received correctly.
- With UART_RX_PARITY_EN: send 0x07 with parity bit 1 -> out_data=0x07. Send the same byte with parity bit 0 -> err_parity pulse, no out_valid.
